// File: rtl/fifo_ctrl_dp.sv
// FIFO controller for a dual-port negedge SRAM: owns pointers, occupancy, flags and error pulses.
// The SRAM holds every data word; this block only steers addresses/enables and registers read data.
module fifo_ctrl_dp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_C     = AF_LEVEL[ADDR_W:0];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push_ok, pop_ok;

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AF_C);
    assign count       = count_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    assign push_ok   = push & ~full & ~flush;
    assign pop_ok    = pop & ~empty & ~flush;
    // Enables are gated by rst_n so the SRAM sees no access while reset is held.
    assign mem_we    = push_ok & rst_n;
    assign mem_re    = pop_ok & rst_n;
    assign mem_waddr = wr_ptr_q;
    assign mem_raddr = rd_ptr_q;
    assign mem_wdata = wr_data;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = pop_ok;
        overflow_d  = push & full & ~flush;
        underflow_d = pop & empty & ~flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop_ok) begin
                rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
                rd_data_d = mem_rdata;
            end
            if (push_ok && !pop_ok) count_d = count_q + (ADDR_W+1)'(1);
            if (pop_ok && !push_ok) count_d = count_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_dp.sv
// Bench for fifo_ctrl_dp: negedge SRAM model plus a queue-based FIFO reference model.
// Directed scenarios pin the model with literal values, then randomized traffic runs.
module tb_fifo_ctrl_dp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, push, pop;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_valid, full, empty, almost_full, overflow, underflow;
    logic [4:0]  count;
    logic        mem_we, mem_re;
    logic [3:0]  mem_waddr, mem_raddr;
    logic [15:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    fifo_ctrl_dp #(.DATA_W(16), .ADDR_W(4), .AF_LEVEL(12)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .wr_data(wr_data),
        .pop(pop), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow),
        .mem_we(mem_we), .mem_re(mem_re), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Dual-port SRAM: both ports act at the negedge; contents survive reset and flush.
    logic [15:0] sram [16];
    always @(negedge clk) begin
        if (mem_we) sram[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_raddr];
    end

    logic [15:0] modelQ[$];
    int          wrCnt, rdCnt;
    logic [15:0] expRdData;
    logic        expRdValid, expOvf, expUnf;
    int          checks = 0;
    int          errors = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        wrCnt = 0; rdCnt = 0;
        expRdData = 16'h0; expRdValid = 1'b0; expOvf = 1'b0; expUnf = 1'b0;
    endtask

    task automatic checkOutput();
        int  sz;
        bit  pushOk, popOk;
        sz     = modelQ.size();
        pushOk = push && (sz < 16) && !flush;
        popOk  = pop && (sz > 0) && !flush;
        checkVal("count", 32'(count), 32'(sz));
        checkVal("full", 32'(full), 32'(sz == 16));
        checkVal("empty", 32'(empty), 32'(sz == 0));
        checkVal("almost_full", 32'(almost_full), 32'(sz >= 12));
        checkVal("rd_valid", 32'(rd_valid), 32'(expRdValid));
        checkVal("overflow", 32'(overflow), 32'(expOvf));
        checkVal("underflow", 32'(underflow), 32'(expUnf));
        if (expRdValid) checkVal("rd_data", 32'(rd_data), 32'(expRdData));
        checkVal("mem_we", 32'(mem_we), 32'(pushOk));
        checkVal("mem_re", 32'(mem_re), 32'(popOk));
        if (pushOk) begin
            checkVal("mem_waddr", 32'(mem_waddr), 32'(wrCnt % 16));
            checkVal("mem_wdata", 32'(mem_wdata), 32'(wr_data));
        end
        if (popOk) checkVal("mem_raddr", 32'(mem_raddr), 32'(rdCnt % 16));
    endtask

    task automatic modelStep();
        int sz;
        bit pushOk, popOk;
        sz         = modelQ.size();
        pushOk     = push && (sz < 16) && !flush;
        popOk      = pop && (sz > 0) && !flush;
        expOvf     = push && (sz == 16) && !flush;
        expUnf     = pop && (sz == 0) && !flush;
        expRdValid = popOk;
        if (flush) begin
            modelQ.delete();
            wrCnt = 0; rdCnt = 0;
        end else begin
            if (popOk) begin
                expRdData = modelQ.pop_front();
                rdCnt++;
            end
            if (pushOk) begin
                modelQ.push_back(wr_data);
                wrCnt++;
            end
        end
    endtask

    // One clock cycle: drive, check mid-cycle, advance model at the posedge.
    task automatic applyStimulus(input logic p, input logic o, input logic f, input logic [15:0] d);
        push = p; pop = o; flush = f; wr_data = d;
        @(negedge clk);
        #1 checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        push = 1'b0; pop = 1'b0; flush = 1'b0; wr_data = 16'h0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int pPush, pPop;
        doReset();
        checkVal("reset empty", 32'(empty), 32'd1);
        checkVal("reset count", 32'(count), 32'd0);

        applyStimulus(1, 0, 0, 16'hA5A5);
        checkVal("t1 count", 32'(count), 32'd1);
        checkVal("t1 empty", 32'(empty), 32'd0);
        applyStimulus(0, 1, 0, 16'h0);
        checkVal("t1 rd_valid", 32'(rd_valid), 32'd1);
        checkVal("t1 rd_data", 32'(rd_data), 32'hA5A5);

        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 16'(i));
        checkVal("t2 full", 32'(full), 32'd1);
        checkVal("t2 count", 32'(count), 32'd16);
        applyStimulus(1, 0, 0, 16'hDEAD);
        checkVal("t2 overflow", 32'(overflow), 32'd1);
        checkVal("t2 count hold", 32'(count), 32'd16);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 0, 16'h0);
            checkVal("t3 rd_data seq", 32'(rd_data), 32'(i));
        end
        checkVal("t3 empty", 32'(empty), 32'd1);
        applyStimulus(0, 1, 0, 16'h0);
        checkVal("t3 underflow", 32'(underflow), 32'd1);
        checkVal("t3 rd_valid", 32'(rd_valid), 32'd0);

        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 16'h100 + 16'(i));
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 16'h0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 16'h200 + 16'(i));
        checkVal("t4 count", 32'(count), 32'd10);

        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 16'h300 + 16'(i));
        applyStimulus(1, 1, 0, 16'hBEEF);
        checkVal("t5 overflow", 32'(overflow), 32'd1);
        checkVal("t5 count 15", 32'(count), 32'd15);
        applyStimulus(0, 0, 1, 16'h0);
        applyStimulus(1, 1, 0, 16'hCAFE);
        checkVal("t5 underflow", 32'(underflow), 32'd1);
        checkVal("t5 count 1", 32'(count), 32'd1);

        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 16'h400 + 16'(i));
        checkVal("t6 count 5", 32'(count), 32'd5);
        applyStimulus(1, 1, 1, 16'h5555);
        checkVal("t6 flush count", 32'(count), 32'd0);
        checkVal("t6 flush empty", 32'(empty), 32'd1);
        checkVal("t6 flush ovf", 32'(overflow), 32'd0);
        checkVal("t6 flush unf", 32'(underflow), 32'd0);

        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 16'h600 + 16'(i));
        push = 1'b1; pop = 1'b1; wr_data = 16'h7777;
        #2 rst_n = 1'b0;
        #1;
        checkVal("async count", 32'(count), 32'd0);
        checkVal("async empty", 32'(empty), 32'd1);
        checkVal("async rd_valid", 32'(rd_valid), 32'd0);
        checkVal("async rd_data", 32'(rd_data), 32'd0);
        checkVal("async mem_we", 32'(mem_we), 32'd0);
        checkVal("async mem_re", 32'(mem_re), 32'd0);
        doReset();
        applyStimulus(1, 0, 0, 16'h1234);
        applyStimulus(0, 1, 0, 16'h0);
        checkVal("post-reset rd_data", 32'(rd_data), 32'h1234);

        for (int blk = 0; blk < 8; blk++) begin
            pPush = (blk % 2 == 0) ? 75 : 30;
            pPop  = (blk % 2 == 0) ? 30 : 75;
            for (int c = 0; c < 100; c++) begin
                applyStimulus(($urandom_range(99) < pPush) ? 1'b1 : 1'b0,
                              ($urandom_range(99) < pPop) ? 1'b1 : 1'b0,
                              ($urandom_range(59) == 0) ? 1'b1 : 1'b0,
                              16'($urandom));
            end
        end
        applyStimulus(0, 0, 0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
